// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register, write-back mux, forwarding tap and retire counter.
// Define WB_LOAD_EXT_EN to enable big-endian sub-word load extraction and LoadFault.
module mem_wb_writeback #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              Clock,
  input  logic              ResetN,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              MemValid,
  input  logic              MemRegWrite,
  input  logic              MemMemtoReg,
  input  logic [4:0]        MemWriteRegister,
  input  logic [DATA_W-1:0] MemAluResult,
  input  logic [DATA_W-1:0] MemReadData,
  input  logic [1:0]        MemLoadSize,
  input  logic              MemLoadUnsigned,
  output logic [4:0]        WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  output logic              RegWrite,
  output logic              FwdValid,
  output logic [4:0]        FwdRegister,
  output logic [DATA_W-1:0] FwdData,
  output logic              LoadFault,
  output logic [CNT_W-1:0]  RetireCount
);

  logic              valid_q;
  logic              regwrite_q;
  logic              memtoreg_q;
  logic [4:0]        wreg_q;
  logic [DATA_W-1:0] alu_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        size_q;
  logic              unsigned_q;
  logic [CNT_W-1:0]  count_q;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      wreg_q     <= '0;
      alu_q      <= '0;
      rdata_q    <= '0;
      size_q     <= '0;
      unsigned_q <= 1'b0;
      count_q    <= '0;
    end else begin
      // Stall and Flush both produce a bubble; the payload is still captured.
      valid_q    <= MemValid & ~Stall & ~Flush;
      regwrite_q <= MemRegWrite;
      memtoreg_q <= MemMemtoReg;
      wreg_q     <= MemWriteRegister;
      alu_q      <= MemAluResult;
      rdata_q    <= MemReadData;
      size_q     <= MemLoadSize;
      unsigned_q <= MemLoadUnsigned;
      count_q    <= count_q + CNT_W'(valid_q);
    end
  end

  logic [DATA_W-1:0] load_data;
  logic              fault;

`ifdef WB_LOAD_EXT_EN
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v    = 8'h00;
    half_v    = 16'h0000;
    load_data = rdata_q;
    fault     = 1'b0;
    unique case (alu_q[1:0])
      2'd0:    byte_v = rdata_q[31:24];
      2'd1:    byte_v = rdata_q[23:16];
      2'd2:    byte_v = rdata_q[15:8];
      default: byte_v = rdata_q[7:0];
    endcase
    half_v = alu_q[1] ? rdata_q[15:0] : rdata_q[31:16];
    unique case (size_q)
      2'b00:   load_data = {{(DATA_W-8){~unsigned_q & byte_v[7]}}, byte_v};
      2'b01: begin
        load_data = {{(DATA_W-16){~unsigned_q & half_v[15]}}, half_v};
        fault     = valid_q & memtoreg_q & alu_q[0];
      end
      default: load_data = rdata_q;
    endcase
  end
`else
  logic unused_load_cfg;
  assign unused_load_cfg = ^{size_q, unsigned_q};
  assign load_data       = rdata_q;
  assign fault           = 1'b0;
`endif

  assign WriteRegister = wreg_q;
  assign WriteData     = memtoreg_q ? load_data : alu_q;
  assign RegWrite      = valid_q & regwrite_q & (wreg_q != 5'd0) & ~fault;
  assign LoadFault     = fault;
  assign FwdValid      = RegWrite;
  assign FwdRegister   = WriteRegister;
  assign FwdData       = WriteData;
  assign RetireCount   = count_q;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Directed self-checking bench for mem_wb_writeback; expectations follow WB_LOAD_EXT_EN.
module tb_mem_wb_writeback;

  logic        Clock = 1'b0;
  logic        ResetN;
  logic        Stall, Flush, MemValid, MemRegWrite, MemMemtoReg, MemLoadUnsigned;
  logic [4:0]  MemWriteRegister;
  logic [31:0] MemAluResult, MemReadData;
  logic [1:0]  MemLoadSize;
  logic [4:0]  WriteRegister, FwdRegister;
  logic [31:0] WriteData, FwdData, RetireCount;
  logic        RegWrite, FwdValid, LoadFault;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

`ifdef WB_LOAD_EXT_EN
  localparam bit Ext = 1'b1;
`else
  localparam bit Ext = 1'b0;
`endif

  mem_wb_writeback #(.DATA_W(32), .CNT_W(32)) dut (
    .Clock(Clock), .ResetN(ResetN), .Stall(Stall), .Flush(Flush), .MemValid(MemValid),
    .MemRegWrite(MemRegWrite), .MemMemtoReg(MemMemtoReg), .MemWriteRegister(MemWriteRegister),
    .MemAluResult(MemAluResult), .MemReadData(MemReadData), .MemLoadSize(MemLoadSize),
    .MemLoadUnsigned(MemLoadUnsigned), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .RegWrite(RegWrite), .FwdValid(FwdValid), .FwdRegister(FwdRegister), .FwdData(FwdData),
    .LoadFault(LoadFault), .RetireCount(RetireCount)
  );

  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic bubble();
    MemValid = 1'b0; Stall = 1'b0; Flush = 1'b0; MemRegWrite = 1'b0;
  endtask

  // Present one op, check WB outputs, then a bubble and check the retire count.
  task automatic run_op(input string tag, input logic vld, input logic stl, input logic fls,
                        input logic rw, input logic m2r, input logic [4:0] rd_reg,
                        input logic [31:0] alu, input logic [31:0] rdata,
                        input logic [1:0] size, input logic uns,
                        input logic [31:0] exp_data, input logic exp_rw,
                        input logic exp_fault, input logic retires);
    MemValid = vld; Stall = stl; Flush = fls; MemRegWrite = rw; MemMemtoReg = m2r;
    MemWriteRegister = rd_reg; MemAluResult = alu; MemReadData = rdata;
    MemLoadSize = size; MemLoadUnsigned = uns;
    tick();
    check_eq({tag, ".RegWrite"}, 32'(RegWrite), 32'(exp_rw));
    check_eq({tag, ".FwdValid"}, 32'(FwdValid), 32'(exp_rw));
    check_eq({tag, ".WriteData"}, WriteData, exp_data);
    check_eq({tag, ".FwdData"}, FwdData, exp_data);
    check_eq({tag, ".WriteRegister"}, 32'(WriteRegister), 32'(rd_reg));
    check_eq({tag, ".FwdRegister"}, 32'(FwdRegister), 32'(rd_reg));
    check_eq({tag, ".LoadFault"}, 32'(LoadFault), 32'(exp_fault));
    check_eq({tag, ".count_before"}, RetireCount, 32'(exp_cnt));
    bubble();
    tick();
    if (retires) exp_cnt++;
    check_eq({tag, ".count_after"}, RetireCount, 32'(exp_cnt));
    check_eq({tag, ".bubble_rw"}, 32'(RegWrite), 32'd0);
  endtask

  initial begin
    ResetN = 1'b0;
    bubble();
    MemMemtoReg = 1'b0; MemWriteRegister = 5'd0; MemAluResult = '0; MemReadData = '0;
    MemLoadSize = 2'b00; MemLoadUnsigned = 1'b0;
    #12;
    check_eq("rst.RegWrite", 32'(RegWrite), 32'd0);
    check_eq("rst.WriteData", WriteData, 32'd0);
    check_eq("rst.WriteRegister", 32'(WriteRegister), 32'd0);
    check_eq("rst.FwdValid", 32'(FwdValid), 32'd0);
    check_eq("rst.FwdData", FwdData, 32'd0);
    check_eq("rst.LoadFault", 32'(LoadFault), 32'd0);
    check_eq("rst.RetireCount", RetireCount, 32'd0);
    ResetN = 1'b1;
    tick();

    run_op("alu", 1, 0, 0, 1, 0, 5'd8, 32'h0000_0005, 32'h0, 2'b00, 0, 32'h5, 1, 0, 1);
    run_op("byte_s2", 1, 0, 0, 1, 1, 5'd9, 32'h0000_1002, 32'h1280_FF34, 2'b00, 0,
           Ext ? 32'hFFFF_FFFF : 32'h1280_FF34, 1, 0, 1);
    run_op("byte_u2", 1, 0, 0, 1, 1, 5'd9, 32'h0000_1002, 32'h1280_FF34, 2'b00, 1,
           Ext ? 32'h0000_00FF : 32'h1280_FF34, 1, 0, 1);
    run_op("byte_s1", 1, 0, 0, 1, 1, 5'd10, 32'h0000_1001, 32'h1280_FF34, 2'b00, 0,
           Ext ? 32'hFFFF_FF80 : 32'h1280_FF34, 1, 0, 1);
    run_op("byte_u0", 1, 0, 0, 1, 1, 5'd11, 32'h0000_1000, 32'h1280_FF34, 2'b00, 1,
           Ext ? 32'h0000_0012 : 32'h1280_FF34, 1, 0, 1);
    run_op("half_s", 1, 0, 0, 1, 1, 5'd12, 32'h0000_2002, 32'h1234_8001, 2'b01, 0,
           Ext ? 32'hFFFF_8001 : 32'h1234_8001, 1, 0, 1);
    run_op("half_u0", 1, 0, 0, 1, 1, 5'd12, 32'h0000_2000, 32'h8234_8001, 2'b01, 1,
           Ext ? 32'h0000_8234 : 32'h8234_8001, 1, 0, 1);
    run_op("half_mis", 1, 0, 0, 1, 1, 5'd13, 32'h0000_2003, 32'h1234_8001, 2'b01, 0,
           Ext ? 32'hFFFF_8001 : 32'h1234_8001, !Ext, Ext, 1);
    run_op("word", 1, 0, 0, 1, 1, 5'd14, 32'h0000_3001, 32'hDEAD_BEEF, 2'b10, 0,
           32'hDEAD_BEEF, 1, 0, 1);
    run_op("rsvd", 1, 0, 0, 1, 1, 5'd15, 32'h0000_3003, 32'hCAFE_0080, 2'b11, 0,
           32'hCAFE_0080, 1, 0, 1);
    run_op("dest0", 1, 0, 0, 1, 0, 5'd0, 32'h0000_0007, 32'h0, 2'b10, 0, 32'h7, 0, 0, 1);
    run_op("norw", 1, 0, 0, 0, 0, 5'd3, 32'h0000_0009, 32'h0, 2'b10, 0, 32'h9, 0, 0, 1);
    run_op("stall", 1, 1, 0, 1, 0, 5'd4, 32'h0000_0021, 32'h0, 2'b10, 0, 32'h21, 0, 0, 0);
    run_op("flush", 1, 0, 1, 1, 0, 5'd4, 32'h0000_0022, 32'h0, 2'b10, 0, 32'h22, 0, 0, 0);
    run_op("stl_fls", 1, 1, 1, 1, 0, 5'd4, 32'h0000_0023, 32'h0, 2'b10, 0, 32'h23, 0, 0, 0);
    run_op("invalid", 0, 0, 0, 1, 0, 5'd4, 32'h0000_0024, 32'h0, 2'b10, 0, 32'h24, 0, 0, 0);

    // Asynchronous reset with a valid op sitting in WB.
    MemValid = 1'b1; MemRegWrite = 1'b1; MemMemtoReg = 1'b0;
    MemWriteRegister = 5'd5; MemAluResult = 32'h0000_0011;
    tick();
    check_eq("pre_rst.RegWrite", 32'(RegWrite), 32'd1);
    bubble();
    #2 ResetN = 1'b0;
    #1;
    exp_cnt = 0;
    check_eq("mid_rst.RegWrite", 32'(RegWrite), 32'd0);
    check_eq("mid_rst.FwdValid", 32'(FwdValid), 32'd0);
    check_eq("mid_rst.WriteData", WriteData, 32'd0);
    check_eq("mid_rst.RetireCount", RetireCount, 32'd0);
    #2 ResetN = 1'b1;
    tick();
    check_eq("post_rst.RetireCount", RetireCount, 32'd0);
    run_op("post_rst", 1, 0, 0, 1, 0, 5'd6, 32'h0000_0042, 32'h0, 2'b10, 0, 32'h42, 1, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
